// File: rtl/mux_key_reverse_search.sv
// Reverse lookup over a packed key/data LUT: returns the key of the first entry
// whose data field equals the requested value, scanning one entry per clock.
module mux_key_reverse_search #(
    parameter int unsigned NR_KEY      = 4,
    parameter int unsigned KEY_LEN     = 2,
    parameter int unsigned DATA_LEN    = 4,
    parameter int unsigned HAS_DEFAULT = 0,
    localparam int unsigned PAIR_LEN   = KEY_LEN + DATA_LEN,
    localparam int unsigned IDX_LEN    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [DATA_LEN-1:0]          req_data,
    input  logic [NR_KEY*PAIR_LEN-1:0]   lut,
    input  logic [KEY_LEN-1:0]           default_key,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [KEY_LEN-1:0]           resp_key,
    output logic [IDX_LEN-1:0]           resp_index,
    output logic                         resp_hit
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                       state_q, state_d;
    logic [IDX_LEN-1:0]           idx_q, idx_d;
    logic [DATA_LEN-1:0]          data_q, data_d;
    logic [NR_KEY*PAIR_LEN-1:0]   lut_q, lut_d;
    logic [KEY_LEN-1:0]           key_d;
    logic [IDX_LEN-1:0]           index_d;
    logic                         hit_d;

    logic [PAIR_LEN-1:0]          cur_pair;
    logic                         is_last;

    // Entry under inspection comes from the captured copy, never the live table
    assign cur_pair  = lut_q[PAIR_LEN*32'(idx_q) +: PAIR_LEN];
    assign is_last   = (idx_q == IDX_LEN'(NR_KEY - 1));
    assign req_ready = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            lut_q      <= '0;
            resp_key   <= '0;
            resp_index <= '0;
            resp_hit   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            lut_q      <= lut_d;
            resp_key   <= key_d;
            resp_index <= index_d;
            resp_hit   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        lut_d   = lut_q;
        key_d   = resp_key;
        index_d = resp_index;
        hit_d   = resp_hit;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    lut_d   = lut;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_pair[DATA_LEN-1:0] == data_q) begin
                    key_d   = cur_pair[PAIR_LEN-1:DATA_LEN];
                    index_d = idx_q;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else if (is_last) begin
                    // Miss: key comes from default_key only when the default is enabled
                    key_d   = (HAS_DEFAULT != 0) ? default_key : '0;
                    index_d = '0;
                    hit_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + IDX_LEN'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_key_reverse_search.sv
// Scoreboard bench: a driver pushes model-predicted responses, a monitor pops and
// compares them; two instances cover both miss-key policies with shared stimulus.
module tb_mux_key_reverse_search;

    localparam int unsigned NR = 4;
    localparam int unsigned KL = 2;
    localparam int unsigned DL = 4;
    localparam int unsigned PL = KL + DL;
    localparam int unsigned IL = 2;
    localparam logic [NR*PL-1:0] BASE_LUT = 24'hE24481;
    localparam logic [NR*PL-1:0] DUP_LUT  = 24'hE24501;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [DL-1:0]     req_data;
    logic [NR*PL-1:0]  lut;
    logic [KL-1:0]     default_key;
    logic              resp_ready;

    logic              req_ready, req_ready_d;
    logic              resp_valid, resp_valid_d;
    logic [KL-1:0]     resp_key, resp_key_d;
    logic [IL-1:0]     resp_index, resp_index_d;
    logic              resp_hit, resp_hit_d;

    mux_key_reverse_search #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .lut(lut), .default_key(default_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_key(resp_key), .resp_index(resp_index), .resp_hit(resp_hit)
    );

    mux_key_reverse_search #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1)) u_dut_def (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_d),
        .req_data(req_data), .lut(lut), .default_key(default_key),
        .resp_valid(resp_valid_d), .resp_ready(resp_ready),
        .resp_key(resp_key_d), .resp_index(resp_index_d), .resp_hit(resp_hit_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KL-1:0] key0;
        logic [KL-1:0] key1;
        logic [IL-1:0] idx;
        logic          hit;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: first entry (lowest index) whose data equals d wins
    function automatic exp_t model(input logic [DL-1:0] d, input logic [NR*PL-1:0] t,
                                   input logic [KL-1:0] dk);
        exp_t e;
        logic [PL-1:0] p;
        e.hit = 1'b0; e.idx = '0; e.key0 = '0; e.key1 = dk; e.lat = NR; e.acc = 0;
        for (int n = NR - 1; n >= 0; n--) begin
            p = t[n*PL +: PL];
            if (p[DL-1:0] == d) begin
                e.hit = 1'b1; e.idx = IL'(n); e.key0 = p[PL-1:DL]; e.key1 = p[PL-1:DL]; e.lat = n + 1;
            end
        end
        return e;
    endfunction

    // Monitor: compares each response against the scoreboard and checks hold stability
    exp_t cur;
    bit   was_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            was_valid = 1'b0;
        end else begin
            check("valid_agree", 32'(resp_valid_d), 32'(resp_valid));
            if (resp_valid && !was_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    cur = exp_q.pop_front();
                    check("resp_key", 32'(resp_key), 32'(cur.key0));
                    check("resp_key_def", 32'(resp_key_d), 32'(cur.key1));
                    check("resp_index", 32'(resp_index), 32'(cur.idx));
                    check("resp_hit", 32'(resp_hit), 32'(cur.hit));
                    check("resp_hit_def", 32'(resp_hit_d), 32'(cur.hit));
                    check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end else if (resp_valid) begin
                check("hold_key", 32'(resp_key), 32'(cur.key0));
                check("hold_index", 32'(resp_index), 32'(cur.idx));
                check("hold_hit", 32'(resp_hit), 32'(cur.hit));
            end
            if (resp_valid) check("ready_low_in_resp", 32'(req_ready), 32'd0);
            was_valid = resp_valid;
        end
    end

    // mode: 0 keep inputs, 1 randomise lut/data after accept, 2 zero all data fields after accept
    task automatic search(input logic [DL-1:0] d, input logic [NR*PL-1:0] t,
                          input int mode, input int hold);
        exp_t e;
        int   w;
        req_data   = d;
        lut        = t;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        if (!req_ready) begin fail_now("req_ready_timeout"); req_valid = 1'b0; return; end
        e = model(d, t, default_key);
        @(negedge clk);
        e.acc = cyc;
        exp_q.push_back(e);
        req_valid = 1'b0;
        if (mode == 1) begin
            lut      = (NR*PL)'($urandom);
            req_data = DL'($urandom);
        end else if (mode == 2) begin
            for (int n = 0; n < NR; n++) lut[n*PL +: DL] = '0;
        end
        w = 0;
        while (!resp_valid && w < 100) begin @(negedge clk); w++; end
        if (!resp_valid) begin fail_now("resp_valid_timeout"); return; end
        if (hold > 0) begin
            req_valid = 1'b1;
            req_data  = d;
            lut       = t;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_valid_held", 32'(resp_valid), 32'd1);
                check("bp_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
            check("bp_release_valid", 32'(resp_valid), 32'd0);
            check("bp_release_ready", 32'(req_ready), 32'd1);
        end else begin
            @(negedge clk);
            check("resp_drop", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [NR*PL-1:0] t;
        logic [DL-1:0]    d;
        logic [PL-1:0]    p;
        rst = 1'b1; req_valid = 1'b0; req_data = '0; lut = BASE_LUT;
        default_key = 2'd2; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_key", 32'(resp_key), 32'd0);
        check("rst_index", 32'(resp_index), 32'd0);
        check("rst_hit", 32'(resp_hit), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);

        search(4'h1, BASE_LUT, 0, 0);
        search(4'h8, BASE_LUT, 0, 0);
        search(4'h4, BASE_LUT, 0, 0);
        search(4'hF, BASE_LUT, 0, 0);
        search(4'h4, DUP_LUT, 0, 0);
        search(4'h2, BASE_LUT, 2, 5);

        // Abort a search at scan index 2 with a one-cycle reset
        req_data = 4'h8; lut = BASE_LUT; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_key", 32'(resp_key), 32'd0);
        check("abort_index", 32'(resp_index), 32'd0);
        check("abort_hit", 32'(resp_hit), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        search(4'h2, BASE_LUT, 0, 0);

        for (int k = 0; k < 40; k++) begin
            t = (NR*PL)'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                p = t[$urandom_range(0, NR - 1)*PL +: PL];
                d = p[DL-1:0];
            end else begin
                d = DL'($urandom);
            end
            default_key = KL'($urandom);
            search(d, t, 1, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
